// File: rtl/tts_pkg.sv
// Shared types and helpers for the truth_table_sweeper block.
package tts_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_e;

  function automatic int pattern_count(input int n_in);
    return 1 << n_in;
  endfunction

endpackage

// File: rtl/truth_table_sweeper_if.sv
// Stimulus/result bundle between a sweep controller (master) and the sweeper (slave).
interface truth_table_sweeper_if #(
  parameter int N_IN = 3
);
  import tts_pkg::*;

  logic                            start;
  logic [pattern_count(N_IN)-1:0]  exp_table;
  logic                            fut_f;
  logic [N_IN-1:0]                 stim;
  logic                            busy;
  logic                            done;
  logic                            pass;
  logic [N_IN:0]                   err_count;
  logic [N_IN-1:0]                 first_fail;

  modport master (
    output start, exp_table, fut_f,
    input  stim, busy, done, pass, err_count, first_fail
  );

  modport slave (
    input  start, exp_table, fut_f,
    output stim, busy, done, pass, err_count, first_fail
  );
endinterface

// File: rtl/tts_hold_timer.sv
// Modulo-HOLD_CYCLES counter; 'last' marks the final settle cycle of a pattern.
module tts_hold_timer #(
  parameter int HOLD_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic last
);
  localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(HOLD_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign last = (cnt_q == LAST_CNT);

  always_comb begin
    // NOTE: default assignment first so every path drives cnt_d and no latch is inferred.
    cnt_d = cnt_q;
    if (clr)     cnt_d = '0;
    else if (en) cnt_d = last ? '0 : cnt_q + CW'(1);
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
endmodule

// File: rtl/truth_table_sweeper.sv
// Sweeps all 2^N_IN input patterns through a combinational FUT and checks it against a golden table.
// Define SWEEP_GRAY_EN to apply the patterns in Gray order instead of binary order.
module truth_table_sweeper
  import tts_pkg::*;
#(
  parameter int N_IN        = 3,
  parameter int HOLD_CYCLES = 4
) (
  input logic                  clk,
  input logic                  rst,
  truth_table_sweeper_if.slave bus
);
  localparam logic [N_IN:0] LAST_IDX = (N_IN+1)'(pattern_count(N_IN) - 1);

  state_e          state_q, state_d;
  logic [N_IN:0]   idx_q, idx_d;
  logic [N_IN-1:0] stim_q, stim_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            pass_q, pass_d;
  logic [N_IN:0]   err_q, err_d;
  logic [N_IN-1:0] ff_q, ff_d;
  logic            tmr_clr, tmr_en, hold_last, mismatch;

  function automatic logic [N_IN-1:0] to_stim(input logic [N_IN-1:0] i);
`ifdef SWEEP_GRAY_EN
    return i ^ (i >> 1);
`else
    return i;
`endif
  endfunction

  tts_hold_timer #(.HOLD_CYCLES(HOLD_CYCLES)) u_hold (
    .clk  (clk),
    .rst  (rst),
    .clr  (tmr_clr),
    .en   (tmr_en),
    .last (hold_last)
  );

  // The golden table is indexed by the pattern actually applied, whatever the order.
  assign mismatch = bus.fut_f ^ bus.exp_table[stim_q];

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    stim_d  = stim_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
    err_d   = err_q;
    ff_d    = ff_q;
    tmr_clr = 1'b0;
    tmr_en  = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d = DRIVE;
          idx_d   = '0;
          stim_d  = to_stim('0);
          busy_d  = 1'b1;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          err_d   = '0;
          ff_d    = '0;
          tmr_clr = 1'b1;
        end
      end
      DRIVE: begin
        tmr_en = 1'b1;
        if (hold_last) begin
          if (mismatch) begin
            err_d = err_q + (N_IN+1)'(1);
            if (err_q == '0) ff_d = stim_q;
          end
          if (idx_q == LAST_IDX) begin
            // stim is left on the final pattern while DONE.
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_d == '0);
          end else begin
            idx_d  = idx_q + (N_IN+1)'(1);
            stim_d = to_stim(idx_d[N_IN-1:0]);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: every flop, results included, is cleared by reset so an aborted sweep leaves no residue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      stim_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      ff_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      stim_q  <= stim_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      ff_q    <= ff_d;
    end
  end

  assign bus.stim       = stim_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.pass       = pass_q;
  assign bus.err_count  = err_q;
  assign bus.first_fail = ff_q;
endmodule

// File: tb/tb_truth_table_sweeper.sv
// Self-checking bench: three sweeper configurations (N3/H4, N1/H4, N3/H1) against a truth-table model.
module tb_truth_table_sweeper;
  localparam int ND = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic       start_r [ND];
  logic [7:0] exp_r   [ND];
  logic [7:0] fut_r   [ND];
  logic [2:0] stim_w  [ND];
  logic [2:0] ff_w    [ND];
  logic [3:0] err_w   [ND];
  logic       busy_w  [ND];
  logic       done_w  [ND];
  logic       pass_w  [ND];

  truth_table_sweeper_if #(.N_IN(3)) bus_a ();
  truth_table_sweeper_if #(.N_IN(1)) bus_b ();
  truth_table_sweeper_if #(.N_IN(3)) bus_c ();

  truth_table_sweeper #(.N_IN(3), .HOLD_CYCLES(4)) dut_a (.clk(clk), .rst(rst), .bus(bus_a.slave));
  truth_table_sweeper #(.N_IN(1), .HOLD_CYCLES(4)) dut_b (.clk(clk), .rst(rst), .bus(bus_b.slave));
  truth_table_sweeper #(.N_IN(3), .HOLD_CYCLES(1)) dut_c (.clk(clk), .rst(rst), .bus(bus_c.slave));

  // FUTs are modelled as truth tables looked up by the applied pattern.
  assign bus_a.start     = start_r[0];
  assign bus_a.exp_table = exp_r[0];
  assign bus_a.fut_f     = fut_r[0][bus_a.stim];
  assign bus_b.start     = start_r[1];
  assign bus_b.exp_table = exp_r[1][1:0];
  assign bus_b.fut_f     = fut_r[1][bus_b.stim];
  assign bus_c.start     = start_r[2];
  assign bus_c.exp_table = exp_r[2];
  assign bus_c.fut_f     = fut_r[2][bus_c.stim];

  assign stim_w[0] = bus_a.stim;            assign stim_w[1] = {2'b00, bus_b.stim};   assign stim_w[2] = bus_c.stim;
  assign ff_w[0]   = bus_a.first_fail;      assign ff_w[1]   = {2'b00, bus_b.first_fail}; assign ff_w[2] = bus_c.first_fail;
  assign err_w[0]  = bus_a.err_count;       assign err_w[1]  = {2'b00, bus_b.err_count};  assign err_w[2] = bus_c.err_count;
  assign busy_w[0] = bus_a.busy;            assign busy_w[1] = bus_b.busy;            assign busy_w[2] = bus_c.busy;
  assign done_w[0] = bus_a.done;            assign done_w[1] = bus_b.done;            assign done_w[2] = bus_c.done;
  assign pass_w[0] = bus_a.pass;            assign pass_w[1] = bus_b.pass;            assign pass_w[2] = bus_c.pass;

  function automatic int n_of(input int w);
    return (w == 1) ? 1 : 3;
  endfunction

  function automatic int h_of(input int w);
    return (w == 2) ? 1 : 4;
  endfunction

  // k-th pattern of a sweep.
  function automatic int order_of(input int k);
`ifdef SWEEP_GRAY_EN
    return k ^ (k >> 1);
`else
    return k;
`endif
  endfunction

  // Expected result: walk the patterns in sweep order, count table disagreements.
  task automatic model(input int w, input logic [7:0] exp_t, input logic [7:0] fut_t,
                       output int err, output int ff);
    int p;
    err = 0;
    ff  = 0;
    for (int k = 0; k < (1 << n_of(w)); k++) begin
      p = order_of(k);
      if (exp_t[p] !== fut_t[p]) begin
        if (err == 0) ff = p;
        err++;
      end
    end
  endtask

  task automatic pulse_start(input int w);
    @(negedge clk);
    start_r[w] = 1'b1;
    @(posedge clk);
    #1;
    start_r[w] = 1'b0;
  endtask

  // Starts a sweep and follows it cycle by cycle until done (or reset injection / timeout).
  task automatic run_sweep(input int w, input int mid_start, input int rst_at,
                           output int cyc, output bit stim_ok, output bit busy_ok, output bit timed_out);
    int h, npat;
    h = h_of(w);
    npat = 1 << n_of(w);
    stim_ok = 1'b1;
    busy_ok = 1'b1;
    timed_out = 1'b0;
    pulse_start(w);
    cyc = 0;
    while (done_w[w] !== 1'b1) begin
      if (cyc >= npat * h + 20) begin
        timed_out = 1'b1;
        break;
      end
      if (cyc / h >= npat || stim_w[w] !== 3'(order_of(cyc / h))) stim_ok = 1'b0;
      if (busy_w[w] !== 1'b1) busy_ok = 1'b0;
      start_r[w] = (cyc == mid_start);
      if (cyc == rst_at) begin
        start_r[w] = 1'b0;
        rst = 1'b1;
        #1;
        return;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    start_r[w] = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int w = 0; w < ND; w++) begin
      start_r[w] = 1'b0;
      exp_r[w] = '0;
      fut_r[w] = '0;
    end
    #2;
    for (int w = 0; w < ND; w++) begin
      n_checks++;
      if ({stim_w[w], busy_w[w], done_w[w], pass_w[w], err_w[w], ff_w[w]} !== '0) begin
        n_fail++;
        $display("FAIL reset_outputs dut%0d: got stim=%0d busy=%0b done=%0b pass=%0b err=%0d ff=%0d, want all 0",
                 w, stim_w[w], busy_w[w], done_w[w], pass_w[w], err_w[w], ff_w[w]);
      end
    end
    pulse_start(0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({busy_w[0], done_w[0]} !== 2'b00) begin
      n_fail++;
      $display("FAIL start_during_rst: got busy=%0b done=%0b, want 0 0", busy_w[0], done_w[0]);
    end
  endtask

  task automatic test_and3();
    int cyc; bit s_ok, b_ok, to;
    exp_r[0] = 8'h80;
    fut_r[0] = 8'h80;
    run_sweep(0, -1, -1, cyc, s_ok, b_ok, to);
    n_checks++;
    if (to || cyc !== 32) begin n_fail++; $display("FAIL and3_latency: got %0d cycles (timeout=%0b), want 32", cyc, to); end
    n_checks++;
    if (!s_ok || !b_ok) begin n_fail++; $display("FAIL and3_stim_busy: got stim_ok=%0b busy_ok=%0b, want 1 1", s_ok, b_ok); end
    n_checks++;
    if ({pass_w[0], err_w[0], busy_w[0]} !== {1'b1, 4'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL and3_result: got pass=%0b err=%0d busy=%0b, want 1 0 0", pass_w[0], err_w[0], busy_w[0]);
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if ({done_w[0], stim_w[0]} !== {1'b1, 3'(order_of(7))}) begin
      n_fail++;
      $display("FAIL and3_done_hold: got done=%0b stim=%0d, want 1 %0d", done_w[0], stim_w[0], order_of(7));
    end
  endtask

  task automatic test_stuck();
    int cyc; bit s_ok, b_ok, to;
    exp_r[0] = 8'h80;
    fut_r[0] = 8'h00;
    run_sweep(0, -1, -1, cyc, s_ok, b_ok, to);
    n_checks++;
    if (to || {err_w[0], ff_w[0], pass_w[0]} !== {4'd1, 3'b111, 1'b0}) begin
      n_fail++;
      $display("FAIL stuck0: got err=%0d ff=%0d pass=%0b, want 1 7 0", err_w[0], ff_w[0], pass_w[0]);
    end
    fut_r[0] = 8'hFF;
    run_sweep(0, -1, -1, cyc, s_ok, b_ok, to);
    n_checks++;
    if (to || {err_w[0], ff_w[0], pass_w[0]} !== {4'd7, 3'b000, 1'b0}) begin
      n_fail++;
      $display("FAIL stuck1: got err=%0d ff=%0d pass=%0b, want 7 0 0", err_w[0], ff_w[0], pass_w[0]);
    end
  endtask

  task automatic test_start_while_busy();
    int cyc, e_err, e_ff; bit s_ok, b_ok, to;
    exp_r[0] = 8'h5A;
    fut_r[0] = 8'h3C;
    model(0, exp_r[0], fut_r[0], e_err, e_ff);
    run_sweep(0, 10, -1, cyc, s_ok, b_ok, to);
    n_checks++;
    if (to || cyc !== 32 || !s_ok || err_w[0] !== 4'(e_err) || ff_w[0] !== 3'(e_ff)) begin
      n_fail++;
      $display("FAIL start_while_busy: got cyc=%0d stim_ok=%0b err=%0d ff=%0d, want 32 1 %0d %0d",
               cyc, s_ok, err_w[0], ff_w[0], e_err, e_ff);
    end
  endtask

  task automatic test_mid_reset();
    int cyc; bit s_ok, b_ok, to;
    exp_r[0] = 8'h80;
    fut_r[0] = 8'hFF;
    run_sweep(0, 10, 20, cyc, s_ok, b_ok, to);
    n_checks++;
    if ({stim_w[0], busy_w[0], done_w[0], pass_w[0], err_w[0], ff_w[0]} !== '0) begin
      n_fail++;
      $display("FAIL mid_reset_outputs: got stim=%0d busy=%0b done=%0b pass=%0b err=%0d ff=%0d, want all 0",
               stim_w[0], busy_w[0], done_w[0], pass_w[0], err_w[0], ff_w[0]);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({busy_w[0], done_w[0]} !== 2'b00) begin
      n_fail++;
      $display("FAIL mid_reset_idle: got busy=%0b done=%0b, want 0 0", busy_w[0], done_w[0]);
    end
    fut_r[0] = 8'h80;
    run_sweep(0, -1, -1, cyc, s_ok, b_ok, to);
    n_checks++;
    if (to || cyc !== 32 || !s_ok || {pass_w[0], err_w[0]} !== {1'b1, 4'd0}) begin
      n_fail++;
      $display("FAIL mid_reset_rerun: got cyc=%0d stim_ok=%0b pass=%0b err=%0d, want 32 1 1 0",
               cyc, s_ok, pass_w[0], err_w[0]);
    end
  endtask

  task automatic test_hold1();
    int cyc; bit s_ok, b_ok, to;
    exp_r[2] = 8'h96;
    fut_r[2] = 8'h96;
    run_sweep(2, -1, -1, cyc, s_ok, b_ok, to);
    n_checks++;
    if (to || cyc !== 8 || !s_ok || !b_ok) begin
      n_fail++;
      $display("FAIL hold1_sequence: got cyc=%0d stim_ok=%0b busy_ok=%0b, want 8 1 1", cyc, s_ok, b_ok);
    end
    n_checks++;
    if ({pass_w[2], err_w[2]} !== {1'b1, 4'd0}) begin
      n_fail++;
      $display("FAIL hold1_xor3: got pass=%0b err=%0d, want 1 0", pass_w[2], err_w[2]);
    end
  endtask

  task automatic test_n1();
    int cyc; bit s_ok, b_ok, to;
    exp_r[1] = 8'h01;
    fut_r[1] = 8'h01;  // ~a
    run_sweep(1, -1, -1, cyc, s_ok, b_ok, to);
    n_checks++;
    if (to || cyc !== 8 || !s_ok || pass_w[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL n1_pass: got cyc=%0d stim_ok=%0b pass=%0b, want 8 1 1", cyc, s_ok, pass_w[1]);
    end
    exp_r[1] = 8'h02;
    run_sweep(1, -1, -1, cyc, s_ok, b_ok, to);
    n_checks++;
    if (to || {err_w[1], ff_w[1], pass_w[1]} !== {4'd2, 3'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL n1_fail: got err=%0d ff=%0d pass=%0b, want 2 0 0", err_w[1], ff_w[1], pass_w[1]);
    end
  endtask

  // Consecutive randomized sweeps restarted straight from DONE; results must not accumulate.
  task automatic test_back_to_back();
    int cyc, w, e_err, e_ff; bit s_ok, b_ok, to;
    for (int it = 0; it < 12; it++) begin
      w = $urandom_range(0, ND - 1);
      exp_r[w] = 8'($urandom);
      fut_r[w] = ($urandom_range(0, 2) == 0) ? exp_r[w] : (exp_r[w] ^ 8'($urandom));
      model(w, exp_r[w], fut_r[w], e_err, e_ff);
      run_sweep(w, -1, -1, cyc, s_ok, b_ok, to);
      n_checks++;
      if (to || cyc !== (1 << n_of(w)) * h_of(w) || !s_ok || !b_ok || err_w[w] !== 4'(e_err)
          || pass_w[w] !== (e_err == 0) || (e_err != 0 && ff_w[w] !== 3'(e_ff))) begin
        n_fail++;
        $display("FAIL back_to_back it%0d dut%0d: got cyc=%0d stim_ok=%0b busy_ok=%0b err=%0d ff=%0d pass=%0b, want cyc=%0d err=%0d ff=%0d",
                 it, w, cyc, s_ok, b_ok, err_w[w], ff_w[w], pass_w[w], (1 << n_of(w)) * h_of(w), e_err, e_ff);
      end
    end
  endtask

  initial begin
    test_reset();
    test_and3();
    test_stuck();
    test_start_while_busy();
    test_mid_reset();
    test_hold1();
    test_n1();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
